// File: rtl/knn_classifier_core_if.sv
// knn_if: software-facing PIO bundle of the k-nearest-neighbour core.
//   master : PIO / software side, drives the write strobe, index, value, k and soft clear.
//   slave  : knn_classifier_core, returns predicted class, valid, busy and full flags.
// Parameters: VALUE_W (attribute value width), CLASS_W (class label width).
interface knn_if #(
  parameter int VALUE_W = 16,
  parameter int CLASS_W = 16
);
  logic               knn_reset_in;
  logic               knn_treinamento_in;
  logic [7:0]         knn_dados_atributo_in;
  logic [VALUE_W-1:0] knn_dados_valor_in;
  logic               knn_dados_pronto_in;
  logic [3:0]         knn_k_in;
  logic [CLASS_W-1:0] knn_classe_prevista_out;
  logic               knn_classe_prevista_pronto_out;
  logic               knn_busy_out;
  logic               knn_full_out;

  modport master (
    output knn_reset_in, knn_treinamento_in, knn_dados_atributo_in, knn_dados_valor_in,
           knn_dados_pronto_in, knn_k_in,
    input  knn_classe_prevista_out, knn_classe_prevista_pronto_out, knn_busy_out, knn_full_out
  );

  modport slave (
    input  knn_reset_in, knn_treinamento_in, knn_dados_atributo_in, knn_dados_valor_in,
           knn_dados_pronto_in, knn_k_in,
    output knn_classe_prevista_out, knn_classe_prevista_pronto_out, knn_busy_out, knn_full_out
  );
endinterface

// File: rtl/knn_classifier_core.sv
// knn_classifier_core: stores training samples written as (index, value) pairs, scans them
// against a query vector, keeps the k nearest in a sorted list and votes the majority class.
// Ports:
//   clk50_0_clk            single clock
//   reset_clk50_0_reset_n  synchronous active-low reset
//   bus (knn_if.slave)     PIO write bundle in, class / valid / busy / full out
// Build option: define KNN_EUCLID_EN for squared-Euclidean distance (one multiplier);
// the default build uses Manhattan distance.
//
// state | meaning
// IDLE  | waiting for writes, no result yet
// SCAN  | accumulating distance one attribute per cycle, then inserting the sample
// VOTE  | k_eff*k_eff cycles of pairwise class matching over the neighbour list
// DONE  | result presented, writes accepted again
module knn_classifier_core #(
  parameter int N_ATTR      = 4,
  parameter int VALUE_W     = 16,
  parameter int CLASS_W     = 16,
  parameter int MAX_SAMPLES = 64,
  parameter int K_MAX       = 15
) (
  input logic  clk50_0_clk,
  input logic  reset_clk50_0_reset_n,
  knn_if.slave bus
);
  localparam int AW  = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
  localparam int ACW = $clog2(N_ATTR + 1);
  localparam int SW  = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
  localparam int CW  = SW + 1;
  localparam int KW  = $clog2(K_MAX + 1);
`ifdef KNN_EUCLID_EN
  localparam int TW  = 2 * VALUE_W;
`else
  localparam int TW  = VALUE_W;
`endif
  localparam int DW  = TW + $clog2(N_ATTR);
  localparam logic [7:0]     COMMIT_IDX = 8'(N_ATTR);
  localparam logic [ACW-1:0] ATTR_LAST  = ACW'(N_ATTR);
  localparam logic [CW-1:0]  CNT_FULL   = CW'(MAX_SAMPLES);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_VOTE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               pronto_prev_q, pronto_prev_d;
  logic [CW-1:0]      count_q, count_d;
  logic [VALUE_W-1:0] stage_q [N_ATTR];
  logic [VALUE_W-1:0] stage_d [N_ATTR];
  logic [VALUE_W-1:0] query_q [N_ATTR];
  logic [VALUE_W-1:0] query_d [N_ATTR];
  logic [SW-1:0]      samp_idx_q, samp_idx_d;
  logic [ACW-1:0]     attr_idx_q, attr_idx_d;
  logic [DW-1:0]      dist_q, dist_d;
  logic [KW-1:0]      k_eff_q, k_eff_d;
  logic [K_MAX-1:0]   nb_valid_q, nb_valid_d;
  logic [DW-1:0]      nb_dist_q [K_MAX];
  logic [DW-1:0]      nb_dist_d [K_MAX];
  logic [CLASS_W-1:0] nb_class_q [K_MAX];
  logic [CLASS_W-1:0] nb_class_d [K_MAX];
  logic [KW-1:0]      vote_i_q, vote_i_d, vote_j_q, vote_j_d;
  logic [KW-1:0]      match_q, match_d, best_cnt_q, best_cnt_d;
  logic [CLASS_W-1:0] best_class_q, best_class_d;
  logic [CLASS_W-1:0] class_out_q, class_out_d;
  logic               pronto_out_q, pronto_out_d;
  logic               busy_q, busy_d;
  logic               full_q, full_d;

  // Training memory has no reset: a soft clear only forgets the sample count.
  logic [VALUE_W-1:0] mem_attr_q [MAX_SAMPLES][N_ATTR];
  logic [CLASS_W-1:0] mem_class_q [MAX_SAMPLES];
  logic               mem_we;
  logic [SW-1:0]      mem_waddr;

  logic               wr_evt, eq;
  logic [VALUE_W-1:0] s_val, q_val, diff;
  logic [TW-1:0]      term;
  logic [K_MAX-1:0]   lt;
  logic [KW-1:0]      tot;
  int unsigned        k_tmp;

  always_comb begin
    s_val = mem_attr_q[samp_idx_q][attr_idx_q[AW-1:0]];
    q_val = query_q[attr_idx_q[AW-1:0]];
    diff  = (q_val >= s_val) ? (q_val - s_val) : (s_val - q_val);
`ifdef KNN_EUCLID_EN
    term  = TW'(diff) * TW'(diff);
`else
    term  = diff;
`endif
    // Strict < keeps earlier (lower-index) samples ahead on equal distance.
    for (int j = 0; j < K_MAX; j++) lt[j] = !nb_valid_q[j] || (dist_q < nb_dist_q[j]);
    eq  = (nb_class_q[vote_i_q] == nb_class_q[vote_j_q]);
    tot = match_q + KW'(eq);
    k_tmp = 32'(bus.knn_k_in);
    if (k_tmp == 0) k_tmp = 1;
    if (k_tmp > K_MAX) k_tmp = K_MAX;
    if (k_tmp > 32'(count_q)) k_tmp = 32'(count_q);
  end

  always_comb begin
    state_d       = state_q;
    pronto_prev_d = bus.knn_dados_pronto_in;
    count_d       = count_q;
    stage_d       = stage_q;
    query_d       = query_q;
    samp_idx_d    = samp_idx_q;
    attr_idx_d    = attr_idx_q;
    dist_d        = dist_q;
    k_eff_d       = k_eff_q;
    nb_valid_d    = nb_valid_q;
    nb_dist_d     = nb_dist_q;
    nb_class_d    = nb_class_q;
    vote_i_d      = vote_i_q;
    vote_j_d      = vote_j_q;
    match_d       = match_q;
    best_cnt_d    = best_cnt_q;
    best_class_d  = best_class_q;
    class_out_d   = class_out_q;
    pronto_out_d  = pronto_out_q;
    mem_we        = 1'b0;
    mem_waddr     = count_q[SW-1:0];
    wr_evt        = bus.knn_dados_pronto_in && !pronto_prev_q &&
                    (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          pronto_out_d = 1'b1;
          class_out_d  = best_class_q;
        end
        if (wr_evt) begin
          if (bus.knn_dados_atributo_in < COMMIT_IDX) begin
            if (bus.knn_treinamento_in)
              stage_d[bus.knn_dados_atributo_in[AW-1:0]] = bus.knn_dados_valor_in;
            else
              query_d[bus.knn_dados_atributo_in[AW-1:0]] = bus.knn_dados_valor_in;
          end else if (bus.knn_dados_atributo_in == COMMIT_IDX) begin
            if (bus.knn_treinamento_in) begin
              if (count_q != CNT_FULL) begin
                mem_we  = !bus.knn_reset_in;
                count_d = count_q + CW'(1);
              end
            end else begin
              pronto_out_d = 1'b0;
              k_eff_d      = KW'(k_tmp);
              nb_valid_d   = '0;
              if (count_q == '0) begin
                best_class_d = '1;
                state_d      = S_DONE;
              end else begin
                samp_idx_d = '0;
                attr_idx_d = '0;
                dist_d     = '0;
                state_d    = S_SCAN;
              end
            end
          end
        end
      end
      S_SCAN: begin
        if (attr_idx_q == ATTR_LAST) begin
          // Sorted insert: first slot where the new distance wins takes it, the rest shift down.
          if (lt[0]) begin
            nb_valid_d[0] = 1'b1;
            nb_dist_d[0]  = dist_q;
            nb_class_d[0] = mem_class_q[samp_idx_q];
          end
          for (int j = 1; j < K_MAX; j++) begin
            if (lt[j] && !lt[j-1]) begin
              nb_valid_d[j] = 1'b1;
              nb_dist_d[j]  = dist_q;
              nb_class_d[j] = mem_class_q[samp_idx_q];
            end else if (lt[j]) begin
              nb_valid_d[j] = nb_valid_q[j-1];
              nb_dist_d[j]  = nb_dist_q[j-1];
              nb_class_d[j] = nb_class_q[j-1];
            end
          end
          dist_d     = '0;
          attr_idx_d = '0;
          if ({1'b0, samp_idx_q} == count_q - CW'(1)) begin
            vote_i_d   = '0;
            vote_j_d   = '0;
            match_d    = '0;
            best_cnt_d = '0;
            state_d    = S_VOTE;
          end else begin
            samp_idx_d = samp_idx_q + SW'(1);
          end
        end else begin
          dist_d     = dist_q + DW'(term);
          attr_idx_d = attr_idx_q + ACW'(1);
        end
      end
      S_VOTE: begin
        if (vote_j_q == k_eff_q - KW'(1)) begin
          // Only a strictly larger count replaces the leader, so ties favour the nearer slot.
          if (tot > best_cnt_q) begin
            best_cnt_d   = tot;
            best_class_d = nb_class_q[vote_i_q];
          end
          match_d  = '0;
          vote_j_d = '0;
          if (vote_i_q == k_eff_q - KW'(1)) state_d = S_DONE;
          else vote_i_d = vote_i_q + KW'(1);
        end else begin
          match_d  = tot;
          vote_j_d = vote_j_q + KW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SCAN) || (state_d == S_VOTE);
    full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk50_0_clk) begin
    if (!reset_clk50_0_reset_n || bus.knn_reset_in) begin
      state_q       <= S_IDLE;
      pronto_prev_q <= 1'b0;
      count_q       <= '0;
      stage_q       <= '{default: '0};
      query_q       <= '{default: '0};
      samp_idx_q    <= '0;
      attr_idx_q    <= '0;
      dist_q        <= '0;
      k_eff_q       <= '0;
      nb_valid_q    <= '0;
      nb_dist_q     <= '{default: '0};
      nb_class_q    <= '{default: '0};
      vote_i_q      <= '0;
      vote_j_q      <= '0;
      match_q       <= '0;
      best_cnt_q    <= '0;
      best_class_q  <= '0;
      class_out_q   <= '0;
      pronto_out_q  <= 1'b0;
      busy_q        <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pronto_prev_q <= pronto_prev_d;
      count_q       <= count_d;
      stage_q       <= stage_d;
      query_q       <= query_d;
      samp_idx_q    <= samp_idx_d;
      attr_idx_q    <= attr_idx_d;
      dist_q        <= dist_d;
      k_eff_q       <= k_eff_d;
      nb_valid_q    <= nb_valid_d;
      nb_dist_q     <= nb_dist_d;
      nb_class_q    <= nb_class_d;
      vote_i_q      <= vote_i_d;
      vote_j_q      <= vote_j_d;
      match_q       <= match_d;
      best_cnt_q    <= best_cnt_d;
      best_class_q  <= best_class_d;
      class_out_q   <= class_out_d;
      pronto_out_q  <= pronto_out_d;
      busy_q        <= busy_d;
      full_q        <= full_d;
    end
  end

  always_ff @(posedge clk50_0_clk) begin
    if (mem_we && reset_clk50_0_reset_n) begin
      mem_attr_q[mem_waddr]  <= stage_q;
      mem_class_q[mem_waddr] <= CLASS_W'(bus.knn_dados_valor_in);
    end
  end

  assign bus.knn_classe_prevista_out        = class_out_q;
  assign bus.knn_classe_prevista_pronto_out = pronto_out_q;
  assign bus.knn_busy_out                   = busy_q;
  assign bus.knn_full_out                   = full_q;
endmodule
